d_cache_ctrl: RTL

// Data-side cache controller: services CPU data_ren/data_wren and raises d_cache_read_miss /
// d_cache_write_miss, which the hazard unit ORs into the pipeline stall.

---
 rtl/d_cache_pkg.sv | 28 ++
 rtl/d_cache_data_ram.sv | 42 ++++
 rtl/d_cache_ctrl.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/d_cache_pkg.sv
// Shared types and width helpers for the data-cache controller.
//   state_e            : controller FSM states
//   off_bits/idx_bits/tag_bits : split of a CPU word address into
//                        line offset, line index and tag
package d_cache_pkg;

  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DRAIN    = 2'd1,
    FILL_REQ = 2'd2,
    FILL     = 2'd3
  } state_e;

  function automatic int off_bits(input int line_words);
    return $clog2(line_words);
  endfunction

  function automatic int idx_bits(input int lines);
    return $clog2(lines);
  endfunction

  function automatic int tag_bits(input int addr_w, input int lines, input int line_words);
    return addr_w - $clog2(lines) - $clog2(line_words);
  endfunction

endpackage

// File: rtl/d_cache_data_ram.sv
// Single-port synchronous data array for the cache.
//   clk, rst_n : clock / async active-low reset (read register only)
//   we_i       : write wdata_i at addr_i
//   re_i       : register mem[addr_i] into rdata_o (old data on read-during-write)
//   rdata_o    : registered read data, holds its value when re_i is low
module d_cache_data_ram
  import d_cache_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = 6,
  parameter int DW    = DATA_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we_i,
  input  logic          re_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  // Output register is resettable so the load data bus starts at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/d_cache_ctrl.sv
// Data-side cache controller: direct-mapped, write-through, no-write-allocate,
// one-entry write buffer, line fills as bursts from the SDRAM arbiter.
//   CPU side : data_ren/data_wren/address/data_in in, data_out out (cycle after
//              a hit), d_cache_read_miss / d_cache_write_miss combinational stalls
//   Mem side : mem_req/mem_we/mem_addr/mem_wdata held until mem_ack;
//              mem_rvalid/mem_rdata deliver a burst, offset 0 first
module d_cache_ctrl
  import d_cache_pkg::*;
#(
  parameter int LINES      = 16,
  parameter int LINE_WORDS = 4,
  parameter int ADDR_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              data_ren,
  input  logic              data_wren,
  input  logic [ADDR_W-1:0] address,
  input  logic [15:0]       data_in,
  output logic [15:0]       data_out,
  output logic              d_cache_read_miss,
  output logic              d_cache_write_miss,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic              mem_rvalid,
  input  logic [15:0]       mem_rdata
);

  localparam int OFF_W  = off_bits(LINE_WORDS);
  localparam int IDX_W  = idx_bits(LINES);
  localparam int TAG_W  = tag_bits(ADDR_W, LINES, LINE_WORDS);
  localparam int LINE_W = ADDR_W - OFF_W;
  localparam int RAM_AW = IDX_W + OFF_W;

  // Address split of the current CPU request
  logic [IDX_W-1:0]  req_idx;
  logic [TAG_W-1:0]  req_tag;
  logic [LINE_W-1:0] req_line;

  assign req_idx  = address[OFF_W +: IDX_W];
  assign req_tag  = address[ADDR_W-1 -: TAG_W];
  assign req_line = address[ADDR_W-1:OFF_W];

  // Tag/valid store
  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_q [LINES];

  // FSM, write buffer, fill tracking
  state_e            state_q, state_d;
  logic              wb_valid_q;
  logic [ADDR_W-1:0] wb_addr_q;
  logic [15:0]       wb_data_q;
  logic [LINE_W-1:0] fill_line_q;
  logic [OFF_W-1:0]  cnt_q;

  logic [IDX_W-1:0]  fill_idx;
  logic [TAG_W-1:0]  fill_tag;
  logic              hit;
  logic              drain_active, drain_ack;
  logic              fill_phase, fill_we, fill_done, fill_start;
  logic              same_line, wr_block, wr_accept, rd_block, rd_accept;
  logic              ram_we;
  logic [RAM_AW-1:0] ram_addr;
  logic [15:0]       ram_wdata;

  assign fill_idx = fill_line_q[IDX_W-1:0];
  assign fill_tag = fill_line_q[LINE_W-1:IDX_W];

  assign hit = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

  // The buffer drains whenever no fill is in progress; a fill never starts
  // until the buffer is empty, so memory always sees writes first.
  assign drain_active = wb_valid_q && ((state_q == IDLE) || (state_q == DRAIN));
  assign drain_ack    = drain_active && mem_ack;

  assign fill_phase = (state_q == FILL_REQ) || (state_q == FILL);
  assign fill_we    = (state_q == FILL) && mem_rvalid;
  assign fill_done  = fill_we && (cnt_q == OFF_W'(LINE_WORDS - 1));

  // A store into the line being fetched would be overwritten by (or race
  // ahead of) the stale burst data, so it waits for the fill to finish.
  assign same_line = fill_phase && (req_line == fill_line_q);

  // The data array has one port: a burst word wins over a store hit or load.
  assign wr_block  = (wb_valid_q && !drain_ack) || same_line || (hit && fill_we);
  assign wr_accept = data_wren && !wr_block;
  assign d_cache_write_miss = data_wren && wr_block;

  assign rd_block  = !hit || fill_we;
  assign rd_accept = data_ren && !rd_block;
  assign d_cache_read_miss = data_ren && rd_block;

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    fill_start = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (data_ren && !hit) begin
          if (wb_valid_q && !drain_ack) begin
            state_d = DRAIN;
          end else begin
            state_d    = FILL_REQ;
            fill_start = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (mem_ack) begin
          state_d    = FILL_REQ;
          fill_start = 1'b1;
        end
      end
      FILL_REQ: begin
        if (mem_ack) begin
          state_d = FILL;
        end
      end
      FILL: begin
        if (fill_done) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Memory request outputs are decoded from registered state only, so they
  // stay stable until mem_ack.
  assign mem_req   = drain_active || (state_q == FILL_REQ);
  assign mem_we    = drain_active;
  assign mem_addr  = drain_active ? wb_addr_q :
                     (state_q == FILL_REQ) ? {fill_line_q, {OFF_W{1'b0}}} : '0;
  assign mem_wdata = drain_active ? wb_data_q : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wb_valid_q  <= 1'b0;
      wb_addr_q   <= '0;
      wb_data_q   <= '0;
      fill_line_q <= '0;
      cnt_q       <= '0;
    end else begin
      state_q <= state_d;
      if (fill_start) begin
        fill_line_q <= req_line;
        cnt_q       <= '0;
      end else if (fill_we) begin
        cnt_q <= cnt_q + OFF_W'(1);
      end
      if (wr_accept) begin
        wb_valid_q <= 1'b1;
        wb_addr_q  <= address;
        wb_data_q  <= data_in;
      end else if (drain_ack) begin
        wb_valid_q <= 1'b0;
      end
    end
  end

  // Per-line tag/valid flops: invalidated when its fill starts so a partly
  // written line never hits, validated on the last burst word.
  for (genvar gi = 0; gi < LINES; gi++) begin : g_line
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q[gi] <= 1'b0;
        tag_q[gi]   <= '0;
      end else if (fill_start && (req_idx == IDX_W'(gi))) begin
        valid_q[gi] <= 1'b0;
      end else if (fill_done && (fill_idx == IDX_W'(gi))) begin
        valid_q[gi] <= 1'b1;
        tag_q[gi]   <= fill_tag;
      end
    end
  end

  // Data array port mux
  assign ram_we    = fill_we || (wr_accept && hit);
  assign ram_addr  = fill_we ? {fill_idx, cnt_q} : address[RAM_AW-1:0];
  assign ram_wdata = fill_we ? mem_rdata : data_in;

  d_cache_data_ram #(
    .DEPTH (LINES * LINE_WORDS),
    .AW    (RAM_AW),
    .DW    (16)
  ) u_data_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (ram_we),
    .re_i    (rd_accept),
    .addr_i  (ram_addr),
    .wdata_i (ram_wdata),
    .rdata_o (data_out)
  );

endmodule
